// File: rtl/hci_tcdm_bank_ts_adapter.sv
// TCDM bank adapter placed between the HCI log interconnect and one SRAM macro.
// Generates r_valid/r_id one cycle after a grant, so the interconnect keeps no
// per-bank response logic. Test-and-set is atomic: the bank reads the old word,
// then locks for one cycle to write TS_VALUE (all ones) to the same address.
module hci_tcdm_bank_ts_adapter #(
    parameter int unsigned AWM = 12,
    parameter int unsigned DW  = 32,
    parameter int unsigned BW  = 8,
    parameter int unsigned UW  = 0,
    parameter int unsigned IW  = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    // Interconnect side
    input  logic                 req_i,
    input  logic [AWM-1:0]       add_i,
    input  logic                 wen_i,
    input  logic [UW+DW-1:0]     wdata_i,
    input  logic [DW/BW-1:0]     be_i,
    input  logic [IW-1:0]        id_i,
    input  logic                 ts_set_i,
    output logic                 gnt_o,
    output logic [UW+DW-1:0]     r_rdata_o,
    output logic                 r_valid_o,
    output logic [IW-1:0]        r_id_o,

    // SRAM side
    output logic                 bank_req_o,
    output logic                 bank_wen_o,
    output logic [AWM-1:0]       bank_add_o,
    output logic [UW+DW-1:0]     bank_wdata_o,
    output logic [DW/BW-1:0]     bank_be_o,
    input  logic [UW+DW-1:0]     bank_rdata_i
);

    localparam int unsigned DataW = UW + DW;
    localparam int unsigned BeW   = DW / BW;

    // Value written by the lock write; covers the user bits as well.
    localparam logic [DataW-1:0] TsValue = {DataW{1'b1}};

    typedef enum logic [0:0] {
        StIdle,
        StTsWr
    } state_e;

    state_e           state_q, state_d;
    logic [AWM-1:0]   addr_q, addr_d;
    logic             r_valid_q, r_valid_d;
    logic [IW-1:0]    r_id_q, r_id_d;

    logic             granted;
    logic             ts_read_start;

    // Request accepted this cycle; only possible while idle.
    assign granted       = req_i & gnt_o;
    // A test-and-set read opens the locked write cycle.
    assign ts_read_start = granted & ts_set_i & wen_i;

    // Grant is withheld only during the lock write.
    assign gnt_o = (state_q == StIdle);

    // Read data goes straight through; the SRAM already delivers it one cycle
    // after the read, which lines up with r_valid_o.
    assign r_rdata_o = bank_rdata_i;
    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;

    // Next-state logic: TS_WR lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (ts_read_start) begin
                    addr_d  = add_i;
                    state_d = StTsWr;
                end
            end
            StTsWr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response tracking: valid for every granted access, ID held otherwise.
    always_comb begin
        r_valid_d = granted;
        r_id_d    = r_id_q;
        if (granted) begin
            r_id_d = id_i;
        end
    end

    // SRAM port: passthrough while idle, forced lock write during TS_WR.
    // Chip enable is gated by reset so a lock write in flight is dropped.
    always_comb begin
        bank_req_o   = req_i;
        bank_wen_o   = wen_i;
        bank_add_o   = add_i;
        bank_wdata_o = wdata_i;
        bank_be_o    = be_i;
        if (state_q == StTsWr) begin
            bank_req_o   = 1'b1;
            bank_wen_o   = 1'b0;
            bank_add_o   = addr_q;
            bank_wdata_o = TsValue;
            bank_be_o    = {BeW{1'b1}};
        end
        if (!rst_ni) begin
            bank_req_o = 1'b0;
        end
    end

    // State and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
        end
    end

endmodule
